// File: rtl/stackcalc_exec_stack.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stackcalc_exec_stack: execution stack with 1-cycle ALU ops and a   |
// | serial shift-and-add MUL. Revision: 1.0                            |
// +--------------------------------------------------------------------+
module stackcalc_exec_stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  input  logic [3:0]                 cmd_op,
  input  logic [WIDTH-1:0]           cmd_data,
  output logic                       cmd_ready,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       err,
  output logic                       busy
);

  localparam int C_DW = $clog2(DEPTH + 1);
  localparam int C_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int C_CW = $clog2(WIDTH + 1);
  localparam logic [C_CW-1:0] C_LAST = C_CW'(WIDTH - 1);
  localparam logic [C_DW-1:0] C_FULL = C_DW'(DEPTH);

  localparam logic [3:0] c_op_push   = 4'd1;
  localparam logic [3:0] c_op_pop    = 4'd2;
  localparam logic [3:0] c_op_add    = 4'd3;
  localparam logic [3:0] c_op_sub    = 4'd4;
  localparam logic [3:0] c_op_and    = 4'd5;
  localparam logic [3:0] c_op_or     = 4'd6;
  localparam logic [3:0] c_op_xor    = 4'd7;
  localparam logic [3:0] c_op_dup    = 4'd8;
  localparam logic [3:0] c_op_swap   = 4'd9;
  localparam logic [3:0] c_op_mul    = 4'd10;
  localparam logic [3:0] c_op_clrerr = 4'd11;

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_MUL_RUN = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [C_DW-1:0]   r_depth;
  logic              r_err;
  logic [WIDTH-1:0]  r_mcand;
  logic [WIDTH-1:0]  r_mplier;
  logic [WIDTH-1:0]  r_acc;
  logic [C_CW-1:0]   r_cnt;

  logic              w_accept;
  logic              w_empty;
  logic              w_full;
  logic              w_ge2;
  logic              w_op_err;
  logic              w_err_set;
  logic              w_last;
  logic [C_AW-1:0]   w_tos_idx;
  logic [C_AW-1:0]   w_nos_idx;
  logic [C_AW-1:0]   w_push_idx;
  logic [WIDTH-1:0]  w_tos;
  logic [WIDTH-1:0]  w_nos;
  logic [WIDTH-1:0]  w_alu;
  logic [WIDTH-1:0]  w_acc_nxt;

  assign busy       = (r_state == S_MUL_RUN);
  assign cmd_ready  = !busy;
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_empty    = (r_depth == '0);
  assign w_full     = (r_depth == C_FULL);
  assign w_ge2      = (r_depth >= C_DW'(2));
  assign w_tos_idx  = C_AW'(r_depth - C_DW'(1));
  assign w_nos_idx  = C_AW'(r_depth - C_DW'(2));
  assign w_push_idx = C_AW'(r_depth);
  assign w_tos      = r_mem[w_tos_idx];
  assign w_nos      = r_mem[w_nos_idx];
  assign w_last     = busy && (r_cnt == C_LAST);
  assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_err_set  = w_accept && w_op_err;

  // Stale entries beyond the occupied depth are masked off.
  assign top   = w_empty ? '0 : w_tos;
  assign depth = r_depth;
  assign err   = r_err;

  always_comb begin
    w_alu    = '0;
    w_op_err = 1'b0;
    case (cmd_op)
      c_op_push: w_op_err = w_full;
      c_op_pop:  w_op_err = w_empty;
      c_op_dup:  w_op_err = w_full || w_empty;
      c_op_add:  begin w_alu = w_nos + w_tos; w_op_err = !w_ge2; end
      c_op_sub:  begin w_alu = w_nos - w_tos; w_op_err = !w_ge2; end
      c_op_and:  begin w_alu = w_nos & w_tos; w_op_err = !w_ge2; end
      c_op_or:   begin w_alu = w_nos | w_tos; w_op_err = !w_ge2; end
      c_op_xor:  begin w_alu = w_nos ^ w_tos; w_op_err = !w_ge2; end
      c_op_swap: w_op_err = !w_ge2;
      c_op_mul:  w_op_err = !w_ge2;
      default:   w_op_err = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_accept && (cmd_op == c_op_mul) && w_ge2) w_state_nxt = S_MUL_RUN;
      S_MUL_RUN: if (w_last) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_depth  <= '0;
      r_err    <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept && (cmd_op == c_op_clrerr)) r_err <= 1'b0;
      else if (w_err_set)                      r_err <= 1'b1;

      if (busy) begin
        // One multiplier bit per cycle; product lands in NOS on the final step.
        r_acc    <= w_acc_nxt;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + C_CW'(1);
        if (w_last) begin
          r_mem[w_nos_idx] <= w_acc_nxt;
          r_depth          <= r_depth - C_DW'(1);
        end
      end else if (w_accept && !w_op_err) begin
        case (cmd_op)
          c_op_push: begin
            r_mem[w_push_idx] <= cmd_data;
            r_depth           <= r_depth + C_DW'(1);
          end
          c_op_pop: r_depth <= r_depth - C_DW'(1);
          c_op_add, c_op_sub, c_op_and, c_op_or, c_op_xor: begin
            r_mem[w_nos_idx] <= w_alu;
            r_depth          <= r_depth - C_DW'(1);
          end
          c_op_dup: begin
            r_mem[w_push_idx] <= w_tos;
            r_depth           <= r_depth + C_DW'(1);
          end
          c_op_swap: begin
            r_mem[w_tos_idx] <= w_nos;
            r_mem[w_nos_idx] <= w_tos;
          end
          c_op_mul: begin
            r_mcand  <= w_nos;
            r_mplier <= w_tos;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stackcalc_exec_stack.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_stackcalc_exec_stack: directed vectors plus multi-cycle MUL,    |
// | overflow and reset-abort sequences. Revision: 1.0                  |
// +--------------------------------------------------------------------+
module tb_stackcalc_exec_stack;

  localparam logic [3:0] NOP = 4'd0, PUSH = 4'd1, POP = 4'd2, ADD = 4'd3,
    SUB = 4'd4, AND_ = 4'd5, OR_ = 4'd6, XOR_ = 4'd7, DUP = 4'd8,
    SWAP = 4'd9, MUL = 4'd10, CLRERR = 4'd11;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [3:0] cmd_op;
  logic [3:0] cmd_data;
  logic       cmd_ready;
  logic [3:0] top;
  logic [3:0] depth;
  logic       err;
  logic       busy;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stackcalc_exec_stack #(.DEPTH(8), .WIDTH(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_ready(cmd_ready), .top(top), .depth(depth),
    .err(err), .busy(busy)
  );

  typedef struct {
    logic       valid;
    logic [3:0] op;
    logic [3:0] data;
    logic [3:0] top;
    logic [3:0] depth;
    logic       err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic v, input logic [3:0] op, input logic [3:0] d,
                     input logic [3:0] t, input logic [3:0] dp, input logic e);
    vec_t x;
    x.valid = v; x.op = op; x.data = d; x.top = t; x.depth = dp; x.err = e;
    vq.push_back(x);
  endtask

  task automatic check(input string name, input logic [3:0] et, input logic [3:0] ed,
                       input logic ee, input logic eb);
    n_vec++;
    if (top !== et || depth !== ed || err !== ee || busy !== eb || cmd_ready !== !eb) begin
      n_fail++;
      $display("FAIL %s: got top=%0d depth=%0d err=%0b busy=%0b ready=%0b, want top=%0d depth=%0d err=%0b busy=%0b ready=%0b",
               name, top, depth, err, busy, cmd_ready, et, ed, ee, eb, !eb);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled at the same point.
  task automatic cmd(input logic v, input logic [3:0] op, input logic [3:0] d);
    cmd_valid = v; cmd_op = op; cmd_data = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = NOP; cmd_data = 4'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic mul_case(input logic [3:0] a, input logic [3:0] b, input logic [3:0] prod);
    int cyc;
    do_reset();
    cmd(1'b1, PUSH, a);
    cmd(1'b1, PUSH, b);
    cmd(1'b1, MUL, 4'd0);
    cyc = 0;
    while (busy && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_vec++;
    if (cyc != 4) begin
      n_fail++;
      $display("FAIL mul_busy_len %0d*%0d: got %0d cycles, want 4", a, b, cyc);
    end
    check($sformatf("mul_%0dx%0d", a, b), prod, 4'd1, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = NOP; cmd_data = 4'd0;
    #1;
    do_reset();
    check("reset", 4'd0, 4'd0, 1'b0, 1'b0);

    add(1, POP,    0, 0, 0, 1);
    add(1, PUSH,   7, 7, 1, 1);
    add(1, ADD,    0, 7, 1, 1);
    add(1, CLRERR, 0, 7, 1, 0);
    add(1, POP,    0, 0, 0, 0);
    add(1, PUSH,   3, 3, 1, 0);
    add(1, PUSH,   5, 5, 2, 0);
    add(1, ADD,    0, 8, 1, 0);
    add(1, PUSH,   2, 2, 2, 0);
    add(1, SUB,    0, 6, 1, 0);
    add(1, PUSH,  15, 15, 2, 0);
    add(1, PUSH,   2, 2, 3, 0);
    add(1, ADD,    0, 1, 2, 0);
    add(1, PUSH,   0, 0, 3, 0);
    add(1, PUSH,   1, 1, 4, 0);
    add(1, SUB,    0, 15, 3, 0);
    add(1, AND_,   0, 1, 2, 0);
    add(1, PUSH,  12, 12, 3, 0);
    add(1, OR_,    0, 13, 2, 0);
    add(1, XOR_,   0, 11, 1, 0);
    add(1, DUP,    0, 11, 2, 0);
    add(1, PUSH,   3, 3, 3, 0);
    add(1, SWAP,   0, 11, 3, 0);
    add(1, POP,    0, 3, 2, 0);
    add(1, NOP,    0, 3, 2, 0);
    add(1, 4'd13,  9, 3, 2, 0);
    add(0, PUSH,   9, 3, 2, 0);
    add(1, POP,    0, 11, 1, 0);
    add(1, SWAP,   0, 11, 1, 1);
    add(1, MUL,    0, 11, 1, 1);
    add(1, CLRERR, 0, 11, 1, 0);
    add(1, POP,    0, 0, 0, 0);
    add(1, DUP,    0, 0, 0, 1);
    add(1, CLRERR, 0, 0, 0, 0);

    foreach (vq[i]) begin
      cmd(vq[i].valid, vq[i].op, vq[i].data);
      check($sformatf("vec%0d", i), vq[i].top, vq[i].depth, vq[i].err, 1'b0);
    end

    // Overflow: ninth push is rejected, stack stays intact through CLRERR.
    do_reset();
    for (int i = 1; i <= 8; i++) cmd(1'b1, PUSH, 4'(i));
    check("full8", 4'd8, 4'd8, 1'b0, 1'b0);
    cmd(1'b1, PUSH, 4'd9);
    check("push_over", 4'd8, 4'd8, 1'b1, 1'b0);
    cmd(1'b1, DUP, 4'd0);
    check("dup_over", 4'd8, 4'd8, 1'b1, 1'b0);
    cmd(1'b1, CLRERR, 4'd0);
    check("clrerr_full", 4'd8, 4'd8, 1'b0, 1'b0);
    for (int i = 8; i >= 2; i--) begin
      cmd(1'b1, POP, 4'd0);
      check($sformatf("drain%0d", i), 4'(i - 1), 4'(i - 1), 1'b0, 1'b0);
    end

    // MUL with a command held valid throughout.
    do_reset();
    cmd(1'b1, PUSH, 4'd3);
    cmd(1'b1, PUSH, 4'd5);
    cmd_valid = 1'b1; cmd_op = MUL; cmd_data = 4'd0;
    @(posedge clk); #1;
    cmd_op = PUSH; cmd_data = 4'd9;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("mul_busy%0d", i), 4'd5, 4'd2, 1'b0, 1'b1);
      @(posedge clk); #1;
    end
    check("mul_done", 4'd15, 4'd1, 1'b0, 1'b0);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = NOP;
    check("held_push", 4'd9, 4'd2, 1'b0, 1'b0);

    mul_case(4'd7, 4'd6, 4'd10);
    mul_case(4'd15, 4'd15, 4'd1);
    mul_case(4'd0, 4'd13, 4'd0);

    // Reset during the second busy cycle aborts the MUL.
    do_reset();
    cmd(1'b1, PUSH, 4'd4);
    cmd(1'b1, PUSH, 4'd4);
    cmd(1'b1, MUL, 4'd0);
    check("abort_busy1", 4'd4, 4'd2, 1'b0, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_rst", 4'd0, 4'd0, 1'b0, 1'b0);

    // Reset wins over a simultaneous PUSH and clears a pending error.
    cmd(1'b1, POP, 4'd0);
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = PUSH; cmd_data = 4'd6;
    @(posedge clk); #1;
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = NOP;
    check("rst_prio", 4'd0, 4'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
